ofdm_sym_scheduler: RTL and testbench

Symbol-framing controller that sits directly upstream of the pilot-insertion stage in the 802.16 OFDM transmit chain. It gates the upstream data stream into per-symbol bursts of DATA_PER_SYM words, opens a fresh CYC cycle for each symbol so the pilot inserter restarts its subcarrier and pilot counters, and holds CYC low for a guard gap between symbols so the inserter drains. It counts symbols per frame and reports frame completion.

---
 rtl/ofdm_sym_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_ofdm_sym_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_sym_scheduler.sv
// ofdm_sym_scheduler
//
// Symbol-framing controller placed directly upstream of the pilot inserter
// in the 802.16 OFDM transmit chain. It gates the upstream word stream into
// bursts of DATA_PER_SYM words. Each burst gets its own downstream bus cycle,
// so the pilot inserter restarts its subcarrier and pilot counters on every
// CYC_O rising edge. Between bursts CYC_O is held low for GAP_CYC cycles so
// the inserter can drain. The block counts symbols per frame and pulses
// DONE_O when the frame is complete.
//
// Ports
//   CLK_I      system clock, rising edge
//   RST_I      synchronous active-high reset
//   START_I    frame start pulse, honoured only while idle
//   ABORT_I    abandon the current frame (everything except RST_I loses to it)
//   NSYM_I     symbols per frame, latched when a start is accepted
//   DAT_I      upstream sample {Im, Re}
//   CYC_I      upstream bus cycle
//   STB_I      upstream strobe
//   WE_I       upstream write enable
//   ACK_O      upstream acknowledge
//   DAT_O      sample to the pilot inserter (zero outside a burst)
//   CYC_O      per-symbol downstream bus cycle, registered
//   STB_O      downstream strobe
//   WE_O       downstream write enable, same as STB_O
//   ACK_I      downstream acknowledge
//   BUSY_O     high whenever a frame is in progress
//   DONE_O     one-cycle pulse at the end of a frame
//   SYM_CNT_O  index of the current symbol within the frame, from 0

module ofdm_sym_scheduler #(
    parameter int DATA_PER_SYM = 192,
    parameter int GAP_CYC      = 64,
    parameter int SYM_W        = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             START_I,
    input  logic             ABORT_I,
    input  logic [SYM_W-1:0] NSYM_I,
    input  logic [31:0]      DAT_I,
    input  logic             CYC_I,
    input  logic             STB_I,
    input  logic             WE_I,
    output logic             ACK_O,
    output logic [31:0]      DAT_O,
    output logic             CYC_O,
    output logic             STB_O,
    output logic             WE_O,
    input  logic             ACK_I,
    output logic             BUSY_O,
    output logic             DONE_O,
    output logic [SYM_W-1:0] SYM_CNT_O
);

    // The word counter only ever needs to hold 0 .. DATA_PER_SYM-1.
    localparam int WCNT_W = (DATA_PER_SYM > 1) ? $clog2(DATA_PER_SYM) : 1;
    // GAP_CYC is limited to 1..255, so an 8-bit gap counter always suffices.
    localparam int GAP_W  = 8;

    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(DATA_PER_SYM - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OPEN = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              cyc_q;
    logic              done_q;
    logic [WCNT_W-1:0] word_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [SYM_W-1:0]  sym_cnt;
    logic [SYM_W-1:0]  nsym_q;

    logic in_xfer;
    logic handshake;
    logic start_ok;
    logic word_last;
    logic gap_last;
    logic sym_last;

    // Bus pass-through is purely combinational so a burst adds no latency;
    // outside XFER the strobe, acknowledge and data are forced to zero so no
    // upstream word can slip through during OPEN, GAP or IDLE.
    always_comb begin
        in_xfer   = (state == ST_XFER);
        STB_O     = in_xfer & CYC_I & STB_I & WE_I;
        WE_O      = STB_O;
        handshake = STB_O & ACK_I;
        ACK_O     = handshake;
        DAT_O     = in_xfer ? DAT_I : 32'd0;
    end

    always_comb begin
        start_ok  = START_I && (NSYM_I != '0);
        word_last = (word_cnt == WORD_LAST);
        gap_last  = (gap_cnt == GAP_LAST);
        sym_last  = (sym_cnt == (nsym_q - SYM_W'(1)));
    end

    // Next-state logic. ABORT_I is applied last so it overrides whatever
    // transition the current state would otherwise take.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_ok) next_state = ST_OPEN;
            ST_OPEN: next_state = ST_XFER;
            ST_XFER: if (handshake && word_last) next_state = ST_GAP;
            ST_GAP:  if (gap_last) next_state = sym_last ? ST_IDLE : ST_OPEN;
            default: next_state = ST_IDLE;
        endcase
        if (ABORT_I) begin
            next_state = ST_IDLE;
        end
    end

    // CYC_O is registered from the next state so it rises with OPEN and
    // falls the cycle after the last handshake or an abort.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= ST_IDLE;
            cyc_q    <= 1'b0;
            done_q   <= 1'b0;
            word_cnt <= '0;
            gap_cnt  <= '0;
            sym_cnt  <= '0;
            nsym_q   <= '0;
        end else begin
            state  <= next_state;
            cyc_q  <= (next_state == ST_OPEN) || (next_state == ST_XFER);
            done_q <= 1'b0;
            if (ABORT_I) begin
                // A handshake in this cycle still completes on the bus but
                // is deliberately not counted.
                word_cnt <= '0;
                gap_cnt  <= '0;
                sym_cnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            nsym_q   <= NSYM_I;
                            sym_cnt  <= '0;
                            word_cnt <= '0;
                            gap_cnt  <= '0;
                        end
                    end
                    ST_XFER: begin
                        if (handshake) begin
                            word_cnt <= word_last ? '0 : word_cnt + WCNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (gap_last) begin
                            gap_cnt <= '0;
                            // The symbol counter stops at NSYM-1, so it never
                            // wraps even with NSYM_I at its maximum.
                            if (sym_last) begin
                                done_q <= 1'b1;
                            end else begin
                                sym_cnt <= sym_cnt + SYM_W'(1);
                            end
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        CYC_O     = cyc_q;
        DONE_O    = done_q;
        BUSY_O    = (state != ST_IDLE);
        SYM_CNT_O = sym_cnt;
    end

endmodule

// File: tb/tb_ofdm_sym_scheduler.sv
// Testbench for ofdm_sym_scheduler.
// An upstream source process presents an endless numbered word stream and
// advances only when a word is acknowledged. Expected words (data and symbol
// index) are queued by the main process before each frame; a monitor pops
// and compares them on every downstream handshake. The main process checks
// cycle-exact framing events against hand-computed cycle numbers.

module tb_ofdm_sym_scheduler;

    localparam logic [31:0] DBASE = 32'h5A00_0000;

    logic        clk;
    logic        RST_I;
    logic        START_I;
    logic        ABORT_I;
    logic [7:0]  NSYM_I;
    logic [31:0] DAT_I;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I;
    logic        BUSY_O;
    logic        DONE_O;
    logic [7:0]  SYM_CNT_O;

    ofdm_sym_scheduler #(
        .DATA_PER_SYM(192),
        .GAP_CYC(64),
        .SYM_W(8)
    ) dut (
        .CLK_I(clk),
        .RST_I(RST_I),
        .START_I(START_I),
        .ABORT_I(ABORT_I),
        .NSYM_I(NSYM_I),
        .DAT_I(DAT_I),
        .CYC_I(CYC_I),
        .STB_I(STB_I),
        .WE_I(WE_I),
        .ACK_O(ACK_O),
        .DAT_O(DAT_O),
        .CYC_O(CYC_O),
        .STB_O(STB_O),
        .WE_O(WE_O),
        .ACK_I(ACK_I),
        .BUSY_O(BUSY_O),
        .DONE_O(DONE_O),
        .SYM_CNT_O(SYM_CNT_O)
    );

    typedef struct {
        logic [31:0] dat;
        logic [7:0]  sym;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int errors  = 0;
    int cycle   = 0;

    bit src_en   = 0;
    bit rnd_mode = 0;
    int src_idx  = 0;
    int push_idx = 0;

    int hs_total  = 0;
    int ack_total = 0;
    int done_cnt  = 0;
    int sym_hs[0:7];
    int first_hs[0:7];
    int last_hs[0:7];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic clearStats();
        hs_total  = 0;
        ack_total = 0;
        done_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            sym_hs[i]   = 0;
            first_hs[i] = -1;
            last_hs[i]  = -1;
        end
    endtask

    // Queue the next n source words as expected downstream words; word k of
    // the frame belongs to symbol k/192.
    task automatic pushFrame(input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.dat = DBASE + 32'(push_idx);
            e.sym = 8'(k / 192);
            exp_q.push_back(e);
            push_idx++;
        end
    endtask

    task automatic gotoCycle(input int c);
        @(negedge clk);
        while (cycle < c) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] nsym, output int at);
        @(posedge clk); #1;
        START_I = 1'b1;
        NSYM_I  = nsym;
        at      = cycle;
        @(posedge clk); #1;
        START_I = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (DONE_O) begin
                at = cycle;
                break;
            end
        end
        vectors++;
        if (at < 0) begin
            errors++;
            $display("[TB] FAIL done_timeout: got no DONE_O, expected one within %0d cycles", limit);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cyc"},  32'(CYC_O), 0);
        checkOutput({tag, "_stb"},  32'(STB_O), 0);
        checkOutput({tag, "_we"},   32'(WE_O), 0);
        checkOutput({tag, "_ack"},  32'(ACK_O), 0);
        checkOutput({tag, "_dat"},  DAT_O, 0);
        checkOutput({tag, "_busy"}, 32'(BUSY_O), 0);
        checkOutput({tag, "_done"}, 32'(DONE_O), 0);
        checkOutput({tag, "_sym"},  32'(SYM_CNT_O), 0);
    endtask

    // Upstream source and downstream acknowledge driver.
    initial begin
        CYC_I = 0; STB_I = 0; WE_I = 0; DAT_I = 0; ACK_I = 0;
        forever begin
            @(posedge clk); #1;
            if (src_en) begin
                CYC_I = 1'b1;
                WE_I  = 1'b1;
                STB_I = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                ACK_I = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
                DAT_I = DBASE + 32'(src_idx);
            end else begin
                CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ACK_I = 1'b0; DAT_I = 32'd0;
            end
            @(negedge clk);
            if (ACK_O) src_idx++;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (STB_O && ACK_I) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("[TB] FAIL extra_word at cycle %0d: got DAT_O %0h, expected no handshake", cycle, DAT_O);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("dat_o", DAT_O, e.dat);
                checkOutput("sym_cnt_o", 32'(SYM_CNT_O), 32'(e.sym));
                checkOutput("ack_o", 32'(ACK_O), 1);
                checkOutput("we_o", 32'(WE_O), 1);
            end
            hs_total++;
            if (SYM_CNT_O < 8) begin
                sym_hs[SYM_CNT_O]++;
                if (sym_hs[SYM_CNT_O] == 1) first_hs[SYM_CNT_O] = cycle;
                last_hs[SYM_CNT_O] = cycle;
            end
        end
        if (ACK_O) ack_total++;
        if (DONE_O) done_cnt++;
    end

    initial begin
        int s;
        int s2;
        int d;
        int dummy;
        RST_I = 1; START_I = 0; ABORT_I = 0; NSYM_I = 0;
        clearStats();

        // Reset state, then idle with an active upstream strobe.
        gotoCycle(3);
        checkResetValues("reset");
        @(posedge clk); #1;
        RST_I  = 0;
        src_en = 1;
        gotoCycle(8);
        checkOutput("idle_ack", 32'(ACK_O), 0);

        // Two-symbol frame, continuous source, START_I at cycle 10.
        pushFrame(384);
        pushFrame(192);
        gotoCycle(9);
        applyStimulus(8'd2, s);
        NSYM_I = 8'd7;
        gotoCycle(11);
        checkOutput("open_cyc", 32'(CYC_O), 1);
        checkOutput("open_busy", 32'(BUSY_O), 1);
        checkOutput("open_stb", 32'(STB_O), 0);
        gotoCycle(12);
        checkOutput("first_stb", 32'(STB_O), 1);
        gotoCycle(100);
        applyStimulus(8'd5, dummy);
        gotoCycle(203);
        checkOutput("last_word_cyc", 32'(CYC_O), 1);
        gotoCycle(204);
        checkOutput("gap_dat", DAT_O, 0);
        for (int c = 204; c <= 267; c++) begin
            if (c > 204) gotoCycle(c);
            checkOutput("gap_quiet", {29'd0, CYC_O, STB_O, ACK_O}, 0);
        end
        gotoCycle(268);
        checkOutput("reopen_cyc", 32'(CYC_O), 1);
        checkOutput("reopen_ack", 32'(ACK_O), 0);
        gotoCycle(524);
        checkOutput("pre_done", 32'(DONE_O), 0);
        checkOutput("pre_done_busy", 32'(BUSY_O), 1);
        gotoCycle(525);
        checkOutput("done_pulse", 32'(DONE_O), 1);
        checkOutput("done_busy", 32'(BUSY_O), 0);
        checkOutput("done_cyc", 32'(CYC_O), 0);
        // Start accepted in the DONE_O cycle.
        START_I = 1'b1;
        NSYM_I  = 8'd1;
        @(posedge clk); #1;
        START_I = 1'b0;
        gotoCycle(526);
        checkOutput("done_len", 32'(DONE_O), 0);
        checkOutput("b2b_cyc", 32'(CYC_O), 1);
        checkOutput("b2b_busy", 32'(BUSY_O), 1);
        checkOutput("sym0_first", 32'(first_hs[0]), 12);
        checkOutput("sym0_last", 32'(last_hs[0]), 203);
        checkOutput("sym1_first", 32'(first_hs[1]), 269);
        checkOutput("sym1_last", 32'(last_hs[1]), 460);
        checkOutput("ack_total", 32'(ack_total), 384);
        checkOutput("hs_total", 32'(hs_total), 384);
        waitDone(600, d);
        checkOutput("b2b_done_cycle", 32'(d), 783);
        gotoCycle(d + 2);
        checkOutput("b2b_done_cnt", 32'(done_cnt), 2);
        checkOutput("sb_empty_1", 32'(exp_q.size()), 0);

        // Random upstream gaps and downstream backpressure, three symbols.
        clearStats();
        rnd_mode = 1;
        pushFrame(576);
        applyStimulus(8'd3, s);
        waitDone(9000, d);
        rnd_mode = 0;
        gotoCycle(d + 2);
        checkOutput("rnd_sym0_hs", 32'(sym_hs[0]), 192);
        checkOutput("rnd_sym1_hs", 32'(sym_hs[1]), 192);
        checkOutput("rnd_sym2_hs", 32'(sym_hs[2]), 192);
        checkOutput("rnd_done_cnt", 32'(done_cnt), 1);
        checkOutput("sb_empty_2", 32'(exp_q.size()), 0);

        // Abort at word 100 of symbol 1; that word still completes on the bus.
        clearStats();
        pushFrame(293);
        applyStimulus(8'd3, s);
        gotoCycle(s + 358);
        @(posedge clk); #1;
        ABORT_I = 1'b1;
        @(negedge clk);
        checkOutput("abort_hs", {30'd0, STB_O, ACK_I}, 3);
        checkOutput("abort_sym", 32'(SYM_CNT_O), 1);
        @(posedge clk); #1;
        ABORT_I = 1'b0;
        gotoCycle(s + 360);
        checkOutput("abort_cyc", 32'(CYC_O), 0);
        checkOutput("abort_busy", 32'(BUSY_O), 0);
        checkOutput("abort_stb", 32'(STB_O), 0);
        checkOutput("abort_sym_clr", 32'(SYM_CNT_O), 0);
        gotoCycle(s + 380);
        checkOutput("abort_hs_total", 32'(hs_total), 293);
        checkOutput("abort_sym1_hs", 32'(sym_hs[1]), 101);
        checkOutput("abort_no_done", 32'(done_cnt), 0);
        checkOutput("sb_empty_3", 32'(exp_q.size()), 0);
        clearStats();
        pushFrame(192);
        applyStimulus(8'd1, s2);
        gotoCycle(s2 + 2);
        checkOutput("post_abort_stb", 32'(STB_O), 1);
        checkOutput("post_abort_sym", 32'(SYM_CNT_O), 0);
        waitDone(400, d);
        checkOutput("post_abort_done_cycle", 32'(d), 32'(s2 + 258));
        gotoCycle(d + 2);
        checkOutput("post_abort_hs", 32'(sym_hs[0]), 192);
        checkOutput("post_abort_done_cnt", 32'(done_cnt), 1);
        checkOutput("sb_empty_4", 32'(exp_q.size()), 0);

        // START_I with NSYM_I = 0 is ignored.
        applyStimulus(8'd0, s);
        gotoCycle(s + 1);
        checkOutput("nsym0_busy", 32'(BUSY_O), 0);
        checkOutput("nsym0_cyc", 32'(CYC_O), 0);
        checkOutput("nsym0_ack", 32'(ACK_O), 0);
        gotoCycle(s + 3);
        checkOutput("nsym0_busy_late", 32'(BUSY_O), 0);

        // Reset asserted during the gap after symbol 0.
        clearStats();
        pushFrame(192);
        applyStimulus(8'd2, s);
        gotoCycle(s + 220);
        checkOutput("gap_before_rst", 32'(CYC_O), 0);
        @(posedge clk); #1;
        RST_I = 1'b1;
        @(posedge clk); #1;
        RST_I = 1'b0;
        @(negedge clk);
        checkResetValues("gap_rst");
        gotoCycle(s + 400);
        checkOutput("rst_no_done", 32'(done_cnt), 0);
        checkOutput("rst_hs_total", 32'(hs_total), 192);
        checkOutput("rst_busy", 32'(BUSY_O), 0);
        checkOutput("sb_empty_5", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
